magnetron_ctrl: RTL

Clocked successor to the combinational start/stop/clear/door/timer logic driving the magnetron SR latch. Replaces the latch with a four-state cooking FSM, detects button presses on edges instead of levels, enforces the door interlock, and modulates the magnetron with a parametrised power-level duty cycle. It sits between the front-panel button/door/timer signals and the magnetron drive output. Legacy-compatible `set_o`/`reset_o` pulses are kept for the existing display path.

---
 rtl/magnetron_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: four-state cooking controller for the magnetron drive.
// Button presses are edge-detected, the door interlock overrides everything,
// and the magnetron is duty-cycled over a MAX_LEVEL*SLOT_CYCLES window.
// All outputs are registered from the next-state so they settle on the
// same edge that samples the triggering input.
module magnetron_ctrl #(
  parameter int MAX_LEVEL   = 10,
  parameter int SLOT_CYCLES = 4,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             comecan,
  input  logic             paren,
  input  logic             limpan,
  input  logic             portafechada,
  input  logic             tdone,
  input  logic [LVL_W-1:0] power_level,
  output logic             magnetron,
  output logic [1:0]       state,
  output logic             set_o,
  output logic             reset_o,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Window length and a counter width wide enough to also hold the
  // on-time limit lvl*SLOT_CYCLES, which can equal the full window.
  localparam int             WIN      = MAX_LEVEL * SLOT_CYCLES;
  localparam int             CW       = $clog2(WIN + 1);
  localparam logic [CW-1:0]  WIN_LAST = CW'(WIN - 1);
  localparam logic [CW-1:0]  SLOT_C   = CW'(SLOT_CYCLES);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [CW-1:0]    on_lim;
  logic             mag_q, set_q, rstp_q, done_q;

  // Button history; released (1) out of reset.
  logic start_prev_q, stop_prev_q, clear_prev_q;
  // Low for the first edge after reset so a button already held low
  // across reset release is absorbed into the history, not seen as a press.
  logic arm_q;

  logic start_p, stop_p, clear_p, door_ok;

  // Press = falling edge of an active-low button, gated until armed.
  always_comb begin
    start_p = arm_q & start_prev_q & ~comecan;
    stop_p  = arm_q & stop_prev_q  & ~paren;
    clear_p = arm_q & clear_prev_q & ~limpan;
    door_ok = portafechada;
  end

  // Sample button history and arm press detection after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
      arm_q        <= 1'b0;
    end else begin
      start_prev_q <= comecan;
      stop_prev_q  <= paren;
      clear_prev_q <= limpan;
      arm_q        <= 1'b1;
    end
  end

  // Next-state: door open, clear, stop, tdone, start in falling priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // Any higher-priority press in the same cycle masks the start.
        if (start_p && !stop_p && !clear_p && door_ok && !tdone)
          state_d = S_COOK;
      end
      S_COOK: begin
        if (!door_ok)     state_d = S_PAUSE;
        else if (clear_p) state_d = S_IDLE;
        else if (stop_p)  state_d = S_PAUSE;
        else if (tdone)   state_d = S_DONE;
      end
      S_PAUSE: begin
        if (clear_p || stop_p)     state_d = S_IDLE;
        else if (tdone)            state_d = S_DONE;
        else if (start_p && door_ok) state_d = S_COOK;
      end
      S_DONE: begin
        if (clear_p || stop_p || !door_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Level latch on IDLE->COOK only; PAUSE->COOK keeps the old level.
  always_comb begin
    lvl_d = lvl_q;
    if (state_q == S_IDLE && state_d == S_COOK) begin
      if (power_level == '0 || power_level > LVL_MAX) lvl_d = LVL_MAX;
      else                                            lvl_d = power_level;
    end
  end

  // Window counter restarts on every COOK entry and idles at 0 elsewhere.
  always_comb begin
    cnt_d = '0;
    if (state_d == S_COOK && state_q == S_COOK)
      cnt_d = (cnt_q == WIN_LAST) ? '0 : cnt_q + 1'b1;
    on_lim = CW'(lvl_d) * SLOT_C;
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lvl_q   <= LVL_MAX;
      mag_q   <= 1'b0;
      set_q   <= 1'b0;
      rstp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      mag_q   <= (state_d == S_COOK) && (cnt_d < on_lim);
      set_q   <= (state_d == S_COOK) && (state_q != S_COOK);
      rstp_q  <= (state_q == S_COOK) && (state_d != S_COOK);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign state     = state_q;
  assign magnetron = mag_q;
  assign set_o     = set_q;
  assign reset_o   = rstp_q;
  assign done      = done_q;

endmodule
